// File: rtl/sum_seq_ctrl.sv
// Streaming word summer: collects up to 8 words at a time into a lane buffer,
// reduces them through one shared 8-input adder tree, and accumulates batches.

module sum_step_1 (
  input  logic [7:0][31:0] lanes,
  output logic [31:0]      sum
);
  logic [31:0] s01, s23, s45, s67, s0123, s4567;

  always_comb begin
    s01   = lanes[0] + lanes[1];
    s23   = lanes[2] + lanes[3];
    s45   = lanes[4] + lanes[5];
    s67   = lanes[6] + lanes[7];
    s0123 = s01 + s23;
    s4567 = s45 + s67;
    sum   = s0123 + s4567;
  end
endmodule

module sum_seq_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] cfg_len,
  output logic             busy,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [31:0]      out_sum,
  input  logic             out_ready
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] FILL   = 2'd1;
  localparam logic [1:0] REDUCE = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0]       state;
  logic [7:0][31:0] lane;
  logic [2:0]       idx;
  logic [CNT_W-1:0] rem;
  logic [31:0]      acc;
  logic [31:0]      tree_out;

  sum_step_1 u_tree (
    .lanes (lane),
    .sum   (tree_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      lane  <= '0;
      idx   <= '0;
      rem   <= '0;
      acc   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            rem   <= cfg_len;
            acc   <= '0;
            idx   <= '0;
            lane  <= '0;
            state <= (cfg_len == '0) ? DONE : FILL;
          end
        end
        FILL: begin
          if (in_valid) begin
            lane[idx] <= in_data;
            idx       <= idx + 3'd1;
            rem       <= rem - CNT_W'(1);
            // A batch closes when the lanes are full or the stream runs out.
            if (idx == 3'd7 || rem == CNT_W'(1)) begin
              state <= REDUCE;
            end
          end
        end
        REDUCE: begin
          acc   <= acc + tree_out;
          lane  <= '0;
          idx   <= '0;
          state <= (rem == '0) ? DONE : FILL;
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign in_ready  = (state == FILL);
  assign out_valid = (state == DONE);
  assign out_sum   = acc;
endmodule

// File: tb/tb_sum_seq_ctrl.sv
// Randomised self-checking bench for sum_seq_ctrl against a transaction-level
// model: expected sum is plain modular addition, expected handshakes follow batch counting.

module tb_sum_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] cfg_len;
  logic        busy;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_sum;
  logic        out_ready;

  int total = 0;
  int bad   = 0;
  logic [31:0] job_q[$];

  int          lat;
  logic [31:0] sum_seen;
  int          gap;

  sum_seq_ctrl #(.CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .cfg_len   (cfg_len),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_sum   (out_sum),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Runs one job starting at a negedge and returns at a negedge after the result handshake.
  task automatic applyStimulus(input int len, input int stall_mode, input int hold, input bit poke,
                               output int latency, output logic [31:0] seen, output int first_gap);
    logic [31:0] model_sum;
    int  accepted;
    bit  in_reduce;
    bit  done;
    bit  finished;
    int  stalls;
    int  done_cycles;
    int  cycle;
    bit  exp_ready;

    model_sum = 32'd0;
    foreach (job_q[i]) model_sum += job_q[i];
    accepted = 0; in_reduce = 0; done = (len == 0); finished = 0;
    stalls = 0; done_cycles = 0; cycle = 0;
    latency = -1; seen = 32'hDEAD_BEEF; first_gap = -1;

    start = 1'b1; cfg_len = 16'(len); in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk);

    while (!finished) begin
      @(negedge clk);
      cycle++;
      exp_ready = !done && !in_reduce;
      checkOutput("busy", {31'd0, busy}, 32'd1);
      checkOutput("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
      checkOutput("out_valid", {31'd0, out_valid}, {31'd0, done});
      if (done) checkOutput("out_sum", out_sum, model_sum);
      if (done && latency < 0) begin
        latency = cycle;
        seen    = out_sum;
        checkOutput("latency_model", 32'(cycle), 32'(1 + len + (len + 7) / 8 + stalls));
      end
      if (!in_ready && !out_valid && first_gap < 0) first_gap = cycle;

      start   = poke && !done && ($urandom_range(0, 2) == 0);
      cfg_len = 16'($urandom);
      case (stall_mode)
        0:       in_valid = exp_ready ? 1'b1 : 1'($urandom);
        1:       in_valid = cycle[0];
        default: in_valid = 1'($urandom);
      endcase
      in_data   = (exp_ready && in_valid) ? job_q[accepted] : $urandom;
      out_ready = done ? (done_cycles >= hold) : 1'($urandom);
      if (exp_ready && !in_valid) stalls++;

      @(posedge clk);
      if (done) begin
        done_cycles++;
        if (out_ready) finished = 1;
      end else if (in_reduce) begin
        in_reduce = 0;
        if (accepted == len) done = 1;
      end else if (in_valid) begin
        accepted++;
        if (accepted % 8 == 0 || accepted == len) in_reduce = 1;
      end

      if (cycle > 3000) begin
        checkOutput("timeout", 32'd1, 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        finished = 1;
      end
    end

    @(negedge clk);
    checkOutput("idle_busy", {31'd0, busy}, 32'd0);
    checkOutput("idle_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("idle_in_ready", {31'd0, in_ready}, 32'd0);
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; cfg_len = '0; in_valid = 1'b0;
    in_data = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_out_sum", out_sum, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    job_q = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
    applyStimulus(8, 0, 0, 0, lat, sum_seen, gap);
    checkOutput("j8_latency", 32'(lat), 32'd10);
    checkOutput("j8_sum", sum_seen, 32'd36);
    checkOutput("j8_reduce_cycle", 32'(gap), 32'd9);

    job_q = {};
    for (int i = 0; i < 11; i++) job_q.push_back(32'h10);
    applyStimulus(11, 0, 0, 0, lat, sum_seen, gap);
    checkOutput("j11_latency", 32'(lat), 32'd14);
    checkOutput("j11_sum", sum_seen, 32'hB0);

    job_q = {32'hFFFF_FFFF, 32'h0000_0002};
    applyStimulus(2, 0, 0, 0, lat, sum_seen, gap);
    checkOutput("wrap_sum", sum_seen, 32'h1);
    checkOutput("wrap_latency", 32'(lat), 32'd4);

    job_q = {32'd100, 32'd200, 32'd300};
    applyStimulus(3, 1, 0, 0, lat, sum_seen, gap);
    checkOutput("toggle_sum", sum_seen, 32'd600);

    job_q = {32'hFFFF_FFFE, 32'd3, 32'd10, 32'd20, 32'd30};
    applyStimulus(5, 0, 5, 1, lat, sum_seen, gap);
    checkOutput("hold_sum", sum_seen, 32'd61);

    job_q = {};
    applyStimulus(0, 0, 0, 0, lat, sum_seen, gap);
    checkOutput("zero_latency", 32'(lat), 32'd1);
    checkOutput("zero_sum", sum_seen, 32'd0);

    // Abort a 16-word job after 5 words, checking the asynchronous clear between edges.
    start = 1'b1; cfg_len = 16'd16;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 32'(1000 + i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("abort_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("abort_out_sum", out_sum, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    job_q = {32'd5, 32'd6, 32'd7, 32'd8};
    applyStimulus(4, 0, 0, 0, lat, sum_seen, gap);
    checkOutput("post_abort_sum", sum_seen, 32'd26);

    for (int j = 0; j < 12; j++) begin
      int n;
      n = $urandom_range(0, 40);
      job_q = {};
      for (int i = 0; i < n; i++) job_q.push_back($urandom);
      applyStimulus(n, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom), lat, sum_seen, gap);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
